truth_table_sweep: RTL and testbench

Sequencer that sits directly upstream of a 4-input combinational function block.
- Drives the block's `a`, `b`, `c`, `d` inputs through all 16 combinations in ascending order, holding each for a programmable dwell time.
- Samples the block's `f` output once per combination and assembles a 16-bit truth table and a minterm count.
- Replaces a hand-written stimulus list with a reusable, self-timed stage that can also run in synthesized hardware.

---
 rtl/truth_table_sweep.sv | 108 ++++++++++
 tb/tb_truth_table_sweep.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep.sv
// Self-timed stimulus sequencer for a 4-input combinational function.
// Walks {a,b,c,d} through 0..15, samples f once per vector and builds the truth table.
module truth_table_sweep #(
  parameter int unsigned DWELL = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  minterm_count,
  output logic [1:0]  state_dbg
);

  // Handshake: start is a level request sampled only in IDLE; done is a
  // one-cycle completion pulse; busy frames the whole drive phase.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      state, state_n;
  logic [3:0]  vec, vec_n;
  logic [7:0]  cnt, cnt_n;
  logic        busy_n, done_n;
  logic [15:0] table_n;
  logic [4:0]  count_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      vec           <= 4'd0;
      cnt           <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth_table   <= 16'h0000;
      minterm_count <= 5'd0;
    end else begin
      state         <= state_n;
      vec           <= vec_n;
      cnt           <= cnt_n;
      busy          <= busy_n;
      done          <= done_n;
      truth_table   <= table_n;
      minterm_count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = done;
    table_n = truth_table;
    count_n = minterm_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = DRIVE;
          vec_n   = 4'd0;
          cnt_n   = 8'd0;
          busy_n  = 1'b1;
          table_n = 16'h0000;
          count_n = 5'd0;
        end
      end
      DRIVE: begin
        if (cnt == LAST) begin
          // f has settled for DWELL cycles on the current vector
          cnt_n        = 8'd0;
          table_n[vec] = f;
          count_n      = minterm_count + {4'd0, f};
          if (vec == 4'd15) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            vec_n   = 4'd0;
          end else begin
            vec_n = vec + 4'd1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        done_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign {a, b, c, d} = vec;
  assign state_dbg    = state;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: four instances with different dwell times, each
// feeding its own function model; completed sweeps are checked from a queue.
module tb_truth_table_sweep;

  localparam int W = 36;

  logic        clock;
  logic        reset;
  logic        start_s [4];
  logic        f_s     [4];
  logic        a_s     [4];
  logic        b_s     [4];
  logic        c_s     [4];
  logic        d_s     [4];
  logic        busy_s  [4];
  logic        done_s  [4];
  logic [15:0] tt_s    [4];
  logic [4:0]  mc_s    [4];
  logic [1:0]  st_s    [4];
  int          mode_s  [4];

  logic [W-1:0] exp_q[$];
  int           blen[4];
  int           checks;
  int           errors;

  // 0: a&b&c&d  1: constant 1  2: a^b^c^d  3: a  4: ~a&~b&c&~d
  function automatic logic fn(int m, logic [3:0] v);
    case (m)
      0:       return v == 4'hF;
      1:       return 1'b1;
      2:       return ^v;
      3:       return v[3];
      4:       return v == 4'h2;
      default: return 1'b0;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int unsigned D = (g == 0) ? 10 : (g == 1) ? 1 : (g == 2) ? 3 : 2;
    truth_table_sweep #(.DWELL(D)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start_s[g]),
      .f            (f_s[g]),
      .a            (a_s[g]),
      .b            (b_s[g]),
      .c            (c_s[g]),
      .d            (d_s[g]),
      .busy         (busy_s[g]),
      .done         (done_s[g]),
      .truth_table  (tt_s[g]),
      .minterm_count(mc_s[g]),
      .state_dbg    (st_s[g])
    );
    assign f_s[g] = fn(mode_s[g], {a_s[g], b_s[g], c_s[g], d_s[g]});
  end

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] mk(int id, int len, logic [4:0] mc, logic [15:0] tt);
    return {id[1:0], 13'(len), mc, tt};
  endfunction

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] outs(int i);
    return {{(W-29){1'b0}}, a_s[i], b_s[i], c_s[i], d_s[i], busy_s[i], done_s[i],
            st_s[i], mc_s[i], tt_s[i]};
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (reset) begin
          blen[i] = 0;
        end else begin
          if (busy_s[i]) blen[i]++;
          if (done_s[i]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: inst %0d table %h", i, tt_s[i]);
            end else begin
              check("sweep_result(id,busy_len,count,table)",
                    mk(i, blen[i], mc_s[i], tt_s[i]), exp_q.pop_front());
            end
            check("vector_after_done", {32'd0, a_s[i], b_s[i], c_s[i], d_s[i]}, '0);
            blen[i] = 0;
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic pulse_start(int i);
    @(negedge clock);
    start_s[i] = 1'b1;
    @(negedge clock);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout(pending)", W'(exp_q.size()), '0);
    exp_q.delete();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int  gap;
    logic prev;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 0;
      blen[i]    = 0;
    end
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) check("reset_outputs", outs(i), '0);

    // AND4, DWELL=10, extra start pulse mid-sweep must be ignored
    mode_s[0] = 0;
    exp_q.push_back(mk(0, 160, 5'd1, 16'h8000));
    pulse_start(0);
    repeat (50) @(negedge clock);
    pulse_start(0);
    wait_drain(400);

    // constant 1, DWELL=1: count reaches 16 without wrapping
    mode_s[1] = 1;
    exp_q.push_back(mk(1, 16, 5'd16, 16'hFFFF));
    pulse_start(1);
    wait_drain(100);

    // parity, DWELL=3, each vector held 3 cycles in ascending order
    mode_s[2] = 2;
    exp_q.push_back(mk(2, 48, 5'd8, 16'h6996));
    @(negedge clock);
    start_s[2] = 1'b1;
    @(negedge clock);
    start_s[2] = 1'b0;
    for (int j = 0; j < 48; j++) begin
      check("parity_vector_hold", {32'd0, a_s[2], b_s[2], c_s[2], d_s[2]}, W'(j / 3));
      @(negedge clock);
    end
    wait_drain(100);

    // start held high for 400 cycles, f=a: three back-to-back sweeps
    mode_s[0] = 3;
    for (int s = 0; s < 3; s++) exp_q.push_back(mk(0, 160, 5'd8, 16'hFF00));
    gap  = 0;
    prev = 1'b0;
    @(negedge clock);
    start_s[0] = 1'b1;
    for (int j = 0; j < 400; j++) begin
      @(negedge clock);
      if (prev && !busy_s[0]) gap = 1;
      else if (!busy_s[0] && gap > 0) gap++;
      else if (busy_s[0] && !prev && gap > 0) begin
        check("b2b_idle_gap", W'(gap), W'(2));
        gap = 0;
      end
      prev = busy_s[0];
    end
    start_s[0] = 1'b0;
    wait_drain(400);

    // asynchronous reset while vec=5, then a clean parity sweep
    mode_s[0] = 2;
    pulse_start(0);
    repeat (54) @(negedge clock);
    check("pre_reset_vec", {32'd0, a_s[0], b_s[0], c_s[0], d_s[0]}, W'(5));
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", outs(0), '0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(mk(0, 160, 5'd8, 16'h6996));
    pulse_start(0);
    wait_drain(400);

    // single minterm 2, DWELL=2; table holds through idle until next start
    mode_s[3] = 4;
    exp_q.push_back(mk(3, 32, 5'd1, 16'h0004));
    pulse_start(3);
    wait_drain(100);
    for (int j = 0; j < 20; j++) begin
      check("idle_hold", {15'd0, mc_s[3], tt_s[3]}, {15'd0, 5'd1, 16'h0004});
      @(negedge clock);
    end
    exp_q.push_back(mk(3, 32, 5'd1, 16'h0004));
    start_s[3] = 1'b1;
    @(negedge clock);
    start_s[3] = 1'b0;
    check("start_clears_table", {15'd0, mc_s[3], tt_s[3]}, '0);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
